prefetch_queue: RTL and testbench

PREFETCH_QUEUE -- requirements
Module: prefetch_queue

---
 rtl/cpu_pkg.sv | 12 +
 rtl/instr_fifo.sv | 61 ++++++
 rtl/prefetch_queue.sv | 101 ++++++++++
 tb/tb_prefetch_queue.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-side definitions: fetch FSM states, default instruction width
// and the sequential fetch stride.
package cpu_pkg;
    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int INSTR_W   = 32;
    localparam int FETCH_INC = 4;
endpackage

// File: rtl/instr_fifo.sv
// Power-of-two circular buffer with push, pop and clear; clear wins over both.
// The head entry is presented combinationally from the storage array.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push && (count_r != CNT_W'(DEPTH));
    assign do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
    assign head_data = mem_r[head_r];
    assign count     = count_r;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            if (do_push_s && !do_pop_s) begin
                count_r <= count_r + CNT_W'(1);
            end else if (!do_push_s && do_pop_s) begin
                count_r <= count_r - CNT_W'(1);
            end
        end
    end

    // Entry storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s && !clear) begin
            mem_r[tail_r] <= push_data;
        end
    end
endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetcher: single-outstanding fetch FSM feeding an instruction
// queue, with redirect flushing both the queue and any in-flight response.
module prefetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = cpu_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_addr,
    input  logic               stall,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  instr_addr
);
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = INSTR_W + ADDR_W;

    fetch_state_t       state_r;
    logic [ADDR_W-1:0]  fetch_pc_r;
    logic [ADDR_W-1:0]  pend_addr_r;
    logic [CNT_W-1:0]   count_s;
    logic [ENTRY_W-1:0] head_s;
    logic               req_fire_s;
    logic               push_s;
    logic               pop_s;

    // Reset gates the request so nothing is offered while reset is held,
    // yet the first request appears in the very first cycle after release.
    assign imem_req_valid = reset && (state_r == REQ) && (count_s < CNT_W'(DEPTH)) && !redirect;
    assign imem_req_addr  = fetch_pc_r;
    assign req_fire_s     = imem_req_valid && imem_req_ready;
    assign push_s         = (state_r == WAIT) && imem_resp_valid && !redirect;
    assign pop_s          = instr_valid && !stall && !redirect;

    assign instr_valid = (count_s != {CNT_W{1'b0}});
    assign instr_out   = instr_valid ? head_s[ENTRY_W-1 -: INSTR_W] : {INSTR_W{1'b0}};
    assign instr_addr  = instr_valid ? head_s[ADDR_W-1:0] : {ADDR_W{1'b0}};

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .clear     (redirect),
        .push      (push_s),
        .push_data ({imem_resp_data, pend_addr_r}),
        .pop       (pop_s),
        .head_data (head_s),
        .count     (count_s)
    );

    // Fetch FSM and PC tracking; redirect overrides every other transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= REQ;
            fetch_pc_r  <= {ADDR_W{1'b0}};
            pend_addr_r <= {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                REQ: begin
                    if (redirect) begin
                        fetch_pc_r <= redirect_addr;
                    end else if (req_fire_s) begin
                        pend_addr_r <= fetch_pc_r;
                        state_r     <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        fetch_pc_r <= redirect_addr;
                        state_r    <= imem_resp_valid ? REQ : DRAIN;
                    end else if (imem_resp_valid) begin
                        fetch_pc_r <= fetch_pc_r + ADDR_W'(FETCH_INC);
                        state_r    <= REQ;
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        fetch_pc_r <= redirect_addr;
                    end
                    if (imem_resp_valid) begin
                        state_r <= REQ;
                    end
                end
                default: begin
                    state_r <= REQ;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue: queue-based reference model checked
// every cycle, directed corner sequences and a table of redirect targets.
module tb_prefetch_queue;
    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_resp_valid;
    logic [INSTR_W-1:0] imem_resp_data;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_addr;
    logic               stall;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr_out;
    logic [ADDR_W-1:0]  instr_addr;

    prefetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .redirect(redirect),
        .redirect_addr(redirect_addr), .stall(stall),
        .instr_valid(instr_valid), .instr_out(instr_out), .instr_addr(instr_addr)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] d; logic [63:0] a; } ent_t;
    typedef struct { logic [63:0] raddr; logic [63:0] a0; logic [63:0] a1; } vec_t;

    int tests = 0;
    int fails = 0;

    // reference model: queue contents, fetch pc, outstanding request status
    ent_t        mq[$];
    logic [63:0] m_pc;
    logic [63:0] m_pend;
    bit          m_out;
    bit          m_stale;

    // memory responder
    bit          r_pend;
    int          r_cnt;
    logic [63:0] r_addr;
    int          resp_lat = 1;
    int          ready_pct = 100;
    int          spur_pct = 0;

    logic [63:0] fired_q[$];
    ent_t        popped_q[$];
    logic        nv_req_valid, nv_instr_valid;
    logic [63:0] nv_req_addr, nv_instr_addr;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5EED_1234;
    endfunction

    function automatic logic [63:0] fq(input int i);
        return (i < fired_q.size()) ? fired_q[i] : 64'hxxxx_xxxx_xxxx_xxxx;
    endfunction

    function automatic logic [63:0] pa(input int i);
        return (i < popped_q.size()) ? popped_q[i].a : 64'hxxxx_xxxx_xxxx_xxxx;
    endfunction

    function automatic logic [31:0] pd(input int i);
        return (i < popped_q.size()) ? popped_q[i].d : 32'hxxxx_xxxx;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc = 64'h0; m_pend = 64'h0; m_out = 1'b0; m_stale = 1'b0;
    endtask

    task automatic model_step(input logic rd, input logic [63:0] ra, input logic st,
                              input logic rdy, input logic rv, input logic [31:0] rdata,
                              input logic exp_rv);
        ent_t e;
        if (!reset) begin
            model_reset();
        end else if (rd) begin
            mq.delete();
            if (m_out) begin
                if (rv) begin m_out = 1'b0; m_stale = 1'b0; end
                else m_stale = 1'b1;
            end
            m_pc = ra;
        end else begin
            if (mq.size() > 0 && !st) void'(mq.pop_front());
            if (m_out && rv) begin
                if (!m_stale) begin
                    e.d = rdata; e.a = m_pend;
                    mq.push_back(e);
                    m_pc = m_pc + 64'd4;
                end
                m_out = 1'b0; m_stale = 1'b0;
            end else if (!m_out && exp_rv && rdy) begin
                m_out = 1'b1; m_pend = m_pc;
            end
        end
    endtask

    // One clock: check at negedge, advance model and memory after posedge.
    task automatic tick();
        logic exp_rv, fire, s_rd, s_st, s_rdy, s_rv;
        logic [63:0] s_ra;
        logic [31:0] s_rdata;
        ent_t e;
        @(negedge clk);
        exp_rv = reset && !m_out && (mq.size() < DEPTH) && !redirect;
        nv_req_valid = imem_req_valid; nv_req_addr = imem_req_addr;
        nv_instr_valid = instr_valid;  nv_instr_addr = instr_addr;
        chk("req_valid", imem_req_valid, exp_rv);
        if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
        chk("instr_valid", instr_valid, reset && (mq.size() > 0));
        if (reset && mq.size() > 0) begin
            chk("instr_out", instr_out, mq[0].d);
            chk("instr_addr", instr_addr, mq[0].a);
        end else if (!reset) begin
            chk("rst_instr_out", instr_out, 64'h0);
            chk("rst_instr_addr", instr_addr, 64'h0);
        end
        fire = imem_req_valid && imem_req_ready;
        if (fire) fired_q.push_back(imem_req_addr);
        if (reset && instr_valid && !stall && !redirect) begin
            e.d = instr_out; e.a = instr_addr;
            popped_q.push_back(e);
        end
        s_rd = redirect; s_ra = redirect_addr; s_st = stall; s_rdy = imem_req_ready;
        s_rv = imem_resp_valid; s_rdata = imem_resp_data;
        @(posedge clk);
        #1;
        model_step(s_rd, s_ra, s_st, s_rdy, s_rv, s_rdata, exp_rv);
        imem_resp_valid = 1'b0;
        if (!reset) begin
            r_pend = 1'b0;
        end else begin
            if (fire) begin r_pend = 1'b1; r_cnt = resp_lat; r_addr = fired_q[$]; end
            if (r_pend) begin
                if (r_cnt <= 1) begin
                    imem_resp_valid = 1'b1; imem_resp_data = mem_word(r_addr); r_pend = 1'b0;
                end else r_cnt--;
            end else if ($urandom_range(0, 99) < spur_pct) begin
                imem_resp_valid = 1'b1; imem_resp_data = $urandom;
            end
        end
        imem_req_ready = ($urandom_range(0, 99) < ready_pct);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        fired_q.delete();
        popped_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[4];
        int first;
        int n;
        vt[0] = '{64'h0000_0000_0000_0100, 64'h0000_0000_0000_0100, 64'h0000_0000_0000_0104};
        vt[1] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_0000};
        vt[2] = '{64'h0000_0000_0000_1000, 64'h0000_0000_0000_1000, 64'h0000_0000_0000_1004};
        vt[3] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC};

        reset = 1'b0; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        redirect = 1'b0; redirect_addr = 64'h0; stall = 1'b0;
        model_reset();
        r_pend = 1'b0;

        // Basic stream after reset release
        do_reset();
        imem_req_ready = 1'b1; resp_lat = 1;
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (first == 0 && nv_instr_valid) first = i;
        end
        chk("first_valid_cycle", first, 3);
        chk("req0", fq(0), 64'h0);
        chk("req1", fq(1), 64'h4);
        chk("req2", fq(2), 64'h8);
        chk("out_addr2", pa(2), 64'h8);
        chk("out_data2", pd(2), mem_word(64'h8));

        // Stall fills the queue, release drains in order
        do_reset();
        imem_req_ready = 1'b1; stall = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("full_req_count", fired_q.size(), 4);
        chk("full_req_valid", nv_req_valid, 1'b0);
        chk("full_head_addr", nv_instr_addr, 64'h0);
        stall = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        chk("drain_a0", pa(0), 64'h0);
        chk("drain_a3", pa(3), 64'hC);
        chk("drain_d3", pd(3), mem_word(64'hC));
        chk("resume_req", fq(4), 64'h10);

        // Redirect while waiting, stale response arrives two cycles later
        do_reset();
        imem_req_ready = 1'b1; resp_lat = 3;
        tick();
        redirect = 1'b1; redirect_addr = 64'h100;
        tick();
        redirect = 1'b0; resp_lat = 1;
        tick();
        chk("drain_no_req", nv_req_valid, 1'b0);
        for (int i = 0; i < 8; i++) tick();
        chk("stale_req0", fq(0), 64'h0);
        chk("stale_req1", fq(1), 64'h100);
        chk("stale_out_a", pa(0), 64'h100);
        chk("stale_out_d", pd(0), mem_word(64'h100));

        // Redirect coincident with response
        do_reset();
        imem_req_ready = 1'b1; resp_lat = 1;
        tick();
        redirect = 1'b1; redirect_addr = 64'h200;
        tick();
        redirect = 1'b0;
        tick();
        chk("coinc_valid", nv_instr_valid, 1'b0);
        chk("coinc_req_valid", nv_req_valid, 1'b1);
        chk("coinc_req_addr", nv_req_addr, 64'h200);
        for (int i = 0; i < 4; i++) tick();
        chk("coinc_out_a", pa(0), 64'h200);

        // Ready held low, then reset mid-WAIT
        do_reset();
        ready_pct = 0; imem_req_ready = 1'b0; stall = 1'b1;
        redirect = 1'b1; redirect_addr = 64'h40;
        tick();
        redirect = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", nv_req_valid, 1'b1);
            chk("hold_addr", nv_req_addr, 64'h40);
        end
        ready_pct = 100; imem_req_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        resp_lat = 3;
        n = fired_q.size();
        for (int i = 0; i < 10 && fired_q.size() == n; i++) tick();
        chk("mid_wait_reached", fired_q.size(), n + 1);
        chk("pre_rst_valid", nv_instr_valid, 1'b1);
        reset = 1'b0;
        #1;
        chk("async_req_valid", imem_req_valid, 1'b0);
        chk("async_instr_valid", instr_valid, 1'b0);
        chk("async_instr_out", instr_out, 64'h0);
        chk("async_instr_addr", instr_addr, 64'h0);
        tick();
        tick();
        reset = 1'b1; stall = 1'b0; resp_lat = 1;
        imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_BAD0;
        fired_q.delete(); popped_q.delete();
        tick();
        chk("post_rst_req", nv_req_valid, 1'b1);
        chk("post_rst_addr", nv_req_addr, 64'h0);
        for (int i = 0; i < 6; i++) tick();
        chk("post_rst_out_a", pa(0), 64'h0);
        chk("post_rst_out_d", pd(0), mem_word(64'h0));

        // Table of redirect targets including address wrap
        for (int v = 0; v < 4; v++) begin
            redirect = 1'b1; redirect_addr = vt[v].raddr;
            tick();
            redirect = 1'b0;
            popped_q.delete();
            for (int i = 0; i < 30 && popped_q.size() < 2; i++) tick();
            chk("tbl_a0", pa(0), vt[v].a0);
            chk("tbl_a1", pa(1), vt[v].a1);
            chk("tbl_d1", pd(1), mem_word(vt[v].a1));
        end

        // Randomised traffic against the reference model
        ready_pct = 70; spur_pct = 5;
        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(0, 99) < 30);
            redirect = ($urandom_range(0, 99) < 4);
            redirect_addr = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFC;
            if ($urandom_range(0, 3) == 0) redirect_addr = 64'hFFFF_FFFF_FFFF_FFF0;
            resp_lat = $urandom_range(1, 3);
            tick();
        end
        redirect = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
